hwag_wheel_gen: RTL and testbench

//  Crank trigger-wheel emulator: produces the toothed-wheel signal (N teeth, M missing) that hwag_core

---
 rtl/hwag_wheel_gen.sv | 80 ++++++++
 tb/tb_hwag_wheel_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hwag_wheel_gen.sv
// hwag_wheel_gen: crank trigger-wheel emulator (N-M toothed wheel) with slot-boundary period updates
module hwag_wheel_gen #(
  parameter int TOOTH_TOTAL = 60,
  parameter int TOOTH_GAP   = 2,
  parameter int PERIOD_W    = 24,
  parameter int CAP_POL     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [PERIOD_W-1:0]            period,
  output logic                           cap,
  output logic [$clog2(TOOTH_TOTAL)-1:0] tooth_num,
  output logic                           gap,
  output logic                           rev_pulse,
  output logic                           busy
);
  localparam int TW = $clog2(TOOTH_TOTAL);
  localparam logic ON = CAP_POL != 0;
  localparam logic OFF = !ON;
  typedef enum logic [1:0] {IDLE, TOOTH_HI, TOOTH_LO, GAP} state_t;
  state_t state;
  logic [PERIOD_W-1:0] cnt, p, p_eff, h;
  logic [TW-1:0] t_next;
  logic last, next_gap;
  assign p_eff = period < PERIOD_W'(2) ? PERIOD_W'(2) : period;
  assign h = p >> 1;
  assign last = cnt == p - PERIOD_W'(1);
  assign t_next = tooth_num == TW'(TOOTH_TOTAL - 1) ? '0 : tooth_num + TW'(1);
  assign next_gap = t_next >= TW'(TOOTH_TOTAL - TOOTH_GAP);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      p <= PERIOD_W'(2);
      tooth_num <= '0;
      cap <= OFF;
      gap <= 1'b0;
      rev_pulse <= 1'b0;
      busy <= 1'b0;
    end else begin
      rev_pulse <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= TOOTH_HI;
          cnt <= '0;
          p <= p_eff;
          tooth_num <= '0;
          cap <= ON;
          gap <= 1'b0;
          rev_pulse <= 1'b1;
          busy <= 1'b1;
        end
        default: if (last) begin
          cnt <= '0;
          if (!enable) begin
            // stop only at a slot boundary; tooth_num keeps the last slot index
            state <= IDLE;
            cap <= OFF;
            gap <= 1'b0;
            busy <= 1'b0;
          end else begin
            p <= p_eff;
            tooth_num <= t_next;
            gap <= next_gap;
            rev_pulse <= t_next == '0;
            cap <= next_gap ? OFF : ON;
            state <= next_gap ? GAP : TOOTH_HI;
          end
        end else begin
          cnt <= cnt + PERIOD_W'(1);
          if (state == TOOTH_HI && cnt == h - PERIOD_W'(1)) begin
            state <= TOOTH_LO;
            cap <= OFF;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hwag_wheel_gen.sv
// tb_hwag_wheel_gen: randomized run against a slot/position wheel model plus literal timing pins
module tb_hwag_wheel_gen;
  localparam int TT = 6;
  localparam int TG = 2;
  localparam int PW = 24;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [PW-1:0] period = PW'(8);
  logic cap, gap, rev_pulse, busy;
  logic [2:0] tooth_num;
  int vectors = 0;
  int miscompares = 0;
  int n, h, l, g;

  hwag_wheel_gen #(.TOOTH_TOTAL(TT), .TOOTH_GAP(TG), .PERIOD_W(PW), .CAP_POL(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .cap(cap), .tooth_num(tooth_num), .gap(gap), .rev_pulse(rev_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // model: running flag, slot index, position in slot, latched slot length
  logic run;
  int slot, pos, per;
  function automatic int clampp(logic [PW-1:0] v);
    return v < 2 ? 2 : int'(v);
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) begin
      run <= 1'b0; slot <= 0; pos <= 0; per <= 2;
    end else if (!run) begin
      if (enable) begin run <= 1'b1; slot <= 0; pos <= 0; per <= clampp(period); end
    end else if (pos == per - 1) begin
      pos <= 0;
      if (enable) begin slot <= (slot + 1) % TT; per <= clampp(period); end
      else run <= 1'b0;
    end else pos <= pos + 1;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_cap", int'(cap), int'(run && slot < TT - TG && pos < per / 2));
    check("m_tooth", int'(tooth_num), slot);
    check("m_gap", int'(gap), int'(run && slot >= TT - TG));
    check("m_rev", int'(rev_pulse), int'(run && slot == 0 && pos == 0));
    check("m_busy", int'(busy), int'(run));
  end

  // call at a negedge showing rev_pulse; returns at the next one
  task automatic run_rev(output int len, output int highs, output int gaps);
    len = 1; highs = int'(cap); gaps = int'(gap);
    @(negedge clk);
    while (!rev_pulse && len < 3000) begin
      len++; highs += int'(cap); gaps += int'(gap);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cap", int'(cap), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tooth", int'(tooth_num), 0);
    rst = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("start_cap", int'(cap), 1);
    check("start_rev", int'(rev_pulse), 1);
    check("start_tooth", int'(tooth_num), 0);
    run_rev(n, h, g);
    check("p8_rev_len", n, 48);
    check("p8_high", h, 16);
    check("p8_gap", g, 16);
    period = PW'(9);
    run_rev(n, h, g);
    run_rev(n, h, g);
    check("p9_rev_len", n, 54);
    check("p9_high", h, 16);
    check("p9_gap", g, 18);
    period = PW'(0);
    run_rev(n, h, g);
    run_rev(n, h, g);
    check("p0_rev_len", n, 12);
    check("p0_high", h, 4);
    period = PW'(8);
    run_rev(n, h, g);
    n = 0;
    repeat (3) @(negedge clk);
    n = 3;
    period = PW'(12);
    do begin @(negedge clk); n++; end while (tooth_num != 3'd1 && n < 500);
    check("chg_old_len", n, 8);
    h = 0; l = 0;
    while (tooth_num == 3'd1 && l < 500) begin h += int'(cap); l++; @(negedge clk); end
    check("chg_new_len", l, 12);
    check("chg_new_high", h, 6);
    n = 0;
    while (tooth_num != 3'd2 && n < 500) begin n++; @(negedge clk); end
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    check("stop_len", n, 11);
    check("stop_cap", int'(cap), 0);
    check("stop_tooth", int'(tooth_num), 2);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("restart_cap", int'(cap), 1);
    check("restart_tooth", int'(tooth_num), 0);
    check("restart_rev", int'(rev_pulse), 1);
    n = 0;
    while (!(cap && tooth_num == 3'd1) && n < 500) begin n++; @(negedge clk); end
    #2 rst = 1'b0;
    #1;
    check("arst_cap", int'(cap), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_tooth", int'(tooth_num), 0);
    @(posedge clk);
    #1;
    check("arst_hold_busy", int'(busy), 0);
    check("arst_hold_cap", int'(cap), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (enable ? $urandom_range(0, 149) == 0 : $urandom_range(0, 4) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) period = PW'($urandom_range(0, 13));
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
